// File: rtl/fft_reader.sv
// fft_reader: drains one magnitude frame from the FFT core after each done
// pulse and captures it into a double-buffered spectrum store with per-bin
// peak-hold and decay. The completed bank is then exposed to the display
// through a registered random-access read port.
module fft_reader #(
  parameter int RN    = 16,
  parameter int SIZE  = 64,
  parameter int DECAY = 3,
  localparam int AW   = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          done,
  output logic          shift,
  input  logic [RN-1:0] fft_data,
  input  logic          en,
  input  logic [AW-1:0] rd_addr,
  output logic [RN-1:0] rd_data,
  output logic [RN-1:0] rd_peak,
  output logic          frame,
  output logic          overrun
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  localparam int          DEPTH      = 2 * SIZE;
  localparam logic [AW-1:0] LAST_IDX   = AW'(SIZE - 1);
  // The core's latch already holds bin 0 and the WAIT shift exposes bin 1,
  // so the final two bins need no further shifting.
  localparam logic [AW-1:0] SHIFT_LAST = AW'(SIZE - 3);

  logic [1:0]    state_reg, state_next;
  logic [AW-1:0] idx_reg, idx_next;
  logic          disp_reg;
  logic          en_lat_reg;
  logic          frame_reg;
  logic [RN-1:0] rd_data_reg;
  logic [RN-1:0] rd_peak_reg;

  // Both banks live in one array; the MSB of the address selects the bank.
  logic [RN-1:0] cur_mem  [DEPTH];
  logic [RN-1:0] peak_mem [DEPTH];

  logic          last_cycle;
  logic          wr_en;
  logic [AW:0]   wr_addr;
  logic [RN-1:0] peak_old;
  logic [RN-1:0] peak_decayed;
  logic [RN-1:0] peak_new;

  assign last_cycle = (state_reg == RUN) && (idx_reg == LAST_IDX);
  assign wr_en      = (state_reg == RUN) && en_lat_reg;
  assign wr_addr    = {~disp_reg, idx_reg};

  // Peak-hold: the previous peak comes from the bank being displayed, the
  // result goes to the bank being filled, so the two never collide.
  assign peak_old     = peak_mem[{disp_reg, idx_reg}];
  assign peak_decayed = peak_old - (peak_old >> DECAY);
  assign peak_new     = (fft_data > peak_decayed) ? fft_data : peak_decayed;

  assign shift   = (state_reg == WAIT) ||
                   ((state_reg == RUN) && (idx_reg <= SHIFT_LAST));
  // A done during a drain is ignored by the core (shift wins over load),
  // so it is only reported.
  assign overrun = done && (state_reg != IDLE);
  assign frame   = frame_reg;
  assign rd_data = rd_data_reg;
  assign rd_peak = rd_peak_reg;

  // Next-state logic for the drain sequencer.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (done) state_next = WAIT;
      end
      WAIT: begin
        state_next = RUN;
        idx_next   = '0;
      end
      RUN: begin
        if (idx_reg == LAST_IDX) begin
          state_next = IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // Sequencer state, per-frame enable latch, bank swap and frame pulse.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      disp_reg   <= 1'b0;
      en_lat_reg <= 1'b0;
      frame_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if ((state_reg == IDLE) && done) en_lat_reg <= en;
      if (last_cycle && en_lat_reg) disp_reg <= ~disp_reg;
      frame_reg <= last_cycle && en_lat_reg;
    end
  end

  // Spectrum store writes; reset clears every entry of both banks.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        cur_mem[i]  <= '0;
        peak_mem[i] <= '0;
      end
    end else if (wr_en) begin
      cur_mem[wr_addr]  <= fft_data;
      peak_mem[wr_addr] <= peak_new;
    end
  end

  // Registered display read from the currently visible bank.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      rd_data_reg <= '0;
      rd_peak_reg <= '0;
    end else begin
      rd_data_reg <= cur_mem[{disp_reg, rd_addr}];
      rd_peak_reg <= peak_mem[{disp_reg, rd_addr}];
    end
  end

endmodule

// File: tb/tb_fft_reader.sv
// Directed bench for fft_reader with SIZE = 8, DECAY = 3 and a small model
// of the FFT core output latch (load on done, advance on shift, registered).
module tb_fft_reader;

  localparam int RN   = 16;
  localparam int SIZE = 8;
  localparam int AW   = 3;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          done;
  logic          shift;
  logic [RN-1:0] fft_data;
  logic          en;
  logic [AW-1:0] rd_addr;
  logic [RN-1:0] rd_data;
  logic [RN-1:0] rd_peak;
  logic          frame;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  logic [RN-1:0] core_mem [SIZE];
  logic [AW-1:0] core_hi = '0;

  fft_reader #(.RN(RN), .SIZE(SIZE), .DECAY(3)) dut (
    .clk(clk), .n_reset(n_reset), .done(done), .shift(shift),
    .fft_data(fft_data), .en(en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_peak(rd_peak), .frame(frame), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Core latch model: shift has priority over load, output registered.
  always @(posedge clk) begin
    if (shift) core_hi <= core_hi + 1'b1;
    else if (done) core_hi <= '0;
    fft_data <= (done && !shift) ? core_mem[0] : core_mem[core_hi];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one done at cycle 0 (and optionally a second done / a reset
  // pulse) and records what the DUT does over ncyc cycles.
  task automatic run_frame(input int ncyc, input int done2_at, input int rst_at,
                           output int n_shift, output int first_shift,
                           output int last_shift, output int n_frame,
                           output int frame_at, output int n_ovr,
                           output int ovr_at, output logic shift_after_rst);
    n_shift = 0; first_shift = -1; last_shift = -1;
    n_frame = 0; frame_at = -1; n_ovr = 0; ovr_at = -1;
    shift_after_rst = 1'bx;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      done    = (c == 0) || (c == done2_at);
      n_reset = (c != rst_at);
      @(negedge clk);
      if (shift === 1'b1) begin
        n_shift++;
        if (first_shift < 0) first_shift = c;
        last_shift = c;
      end
      if (frame === 1'b1) begin
        n_frame++;
        if (frame_at < 0) frame_at = c;
      end
      if (overrun === 1'b1) begin
        n_ovr++;
        if (ovr_at < 0) ovr_at = c;
      end
      if (c == rst_at + 1) shift_after_rst = shift;
    end
    @(posedge clk); #1;
    done = 1'b0;
    n_reset = 1'b1;
  endtask

  task automatic read_bin(input logic [AW-1:0] a, output logic [RN-1:0] d,
                          output logic [RN-1:0] p);
    @(posedge clk); #1;
    rd_addr = a;
    @(posedge clk); #1;
    d = rd_data;
    p = rd_peak;
  endtask

  task automatic test_reset;
    n_reset = 1'b0; done = 1'b0; en = 1'b1; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    if ({shift, frame, overrun} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: shift/frame/overrun=%b required 000", {shift, frame, overrun});
    end
    checks++;
    if (rd_data !== 16'd0 || rd_peak !== 16'd0) begin
      errors++; $display("FAIL reset_read: rd_data=%0d rd_peak=%0d required 0 0", rd_data, rd_peak);
    end
    checks++;
    n_reset = 1'b1;
    $display("reset: shift=%b frame=%b overrun=%b rd_data=%0d", shift, frame, overrun, rd_data);
  endtask

  task automatic test_first_frame;
    int ns, fs, ls, nf, fa, no, oa; logic sar;
    logic [RN-1:0] d, p;
    core_mem = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80};
    run_frame(14, -1, -1, ns, fs, ls, nf, fa, no, oa, sar);
    $display("first_frame: shifts=%0d first=%0d last=%0d frames=%0d at=%0d overruns=%0d", ns, fs, ls, nf, fa, no);
    if (ns !== 7 || fs !== 1 || ls !== 7) begin
      errors++; $display("FAIL first_shift: count=%0d first=%0d last=%0d required 7 1 7", ns, fs, ls);
    end
    checks++;
    if (nf !== 1 || fa !== 10 || no !== 0) begin
      errors++; $display("FAIL first_frame_pulse: frames=%0d at=%0d overruns=%0d required 1 10 0", nf, fa, no);
    end
    checks++;
    for (int k = 0; k < SIZE; k++) begin
      read_bin(AW'(k), d, p);
      $display("first_frame read bin %0d: data=%0d peak=%0d", k, d, p);
      if (d !== core_mem[k] || p !== core_mem[k]) begin
        errors++; $display("FAIL first_read bin %0d: data=%0d peak=%0d required %0d %0d", k, d, p, core_mem[k], core_mem[k]);
      end
      checks++;
    end
  endtask

  task automatic test_decay;
    int ns, fs, ls, nf, fa, no, oa; logic sar;
    logic [RN-1:0] d, p;
    logic [RN-1:0] exp_peak [SIZE];
    exp_peak = '{16'd9, 16'd18, 16'd27, 16'd35, 16'd44, 16'd53, 16'd62, 16'd70};
    core_mem = '{default: 16'd0};
    run_frame(14, -1, -1, ns, fs, ls, nf, fa, no, oa, sar);
    $display("decay: shifts=%0d frames=%0d at=%0d", ns, nf, fa);
    if (nf !== 1 || fa !== 10) begin
      errors++; $display("FAIL decay_frame: frames=%0d at=%0d required 1 10", nf, fa);
    end
    checks++;
    for (int k = 0; k < SIZE; k++) begin
      read_bin(AW'(k), d, p);
      $display("decay read bin %0d: data=%0d peak=%0d", k, d, p);
      if (d !== 16'd0 || p !== exp_peak[k]) begin
        errors++; $display("FAIL decay_read bin %0d: data=%0d peak=%0d required 0 %0d", k, d, p, exp_peak[k]);
      end
      checks++;
    end
  endtask

  task automatic test_freeze;
    int ns, fs, ls, nf, fa, no, oa; logic sar;
    logic [RN-1:0] d, p;
    logic [RN-1:0] old_peak [SIZE];
    logic [RN-1:0] new_peak [SIZE];
    old_peak = '{16'd9, 16'd18, 16'd27, 16'd35, 16'd44, 16'd53, 16'd62, 16'd70};
    new_peak = '{16'd8, 16'd100, 16'd24, 16'd300, 16'd39, 16'd47, 16'd62, 16'd62};
    en = 1'b0;
    core_mem = '{default: 16'd500};
    run_frame(14, -1, -1, ns, fs, ls, nf, fa, no, oa, sar);
    en = 1'b1;
    $display("freeze: shifts=%0d frames=%0d", ns, nf);
    if (ns !== 7 || nf !== 0) begin
      errors++; $display("FAIL freeze_ctrl: shifts=%0d frames=%0d required 7 0", ns, nf);
    end
    checks++;
    for (int k = 0; k < SIZE; k++) begin
      read_bin(AW'(k), d, p);
      if (d !== 16'd0 || p !== old_peak[k]) begin
        errors++; $display("FAIL freeze_read bin %0d: data=%0d peak=%0d required 0 %0d", k, d, p, old_peak[k]);
      end
      checks++;
    end
    core_mem = '{16'd5, 16'd100, 16'd3, 16'd300, 16'd20, 16'd1, 16'd62, 16'd0};
    run_frame(14, -1, -1, ns, fs, ls, nf, fa, no, oa, sar);
    $display("unfreeze: shifts=%0d frames=%0d at=%0d", ns, nf, fa);
    if (nf !== 1 || fa !== 10) begin
      errors++; $display("FAIL unfreeze_frame: frames=%0d at=%0d required 1 10", nf, fa);
    end
    checks++;
    for (int k = 0; k < SIZE; k++) begin
      read_bin(AW'(k), d, p);
      $display("unfreeze read bin %0d: data=%0d peak=%0d", k, d, p);
      if (d !== core_mem[k] || p !== new_peak[k]) begin
        errors++; $display("FAIL unfreeze_read bin %0d: data=%0d peak=%0d required %0d %0d", k, d, p, core_mem[k], new_peak[k]);
      end
      checks++;
    end
  endtask

  task automatic test_overrun;
    int ns, fs, ls, nf, fa, no, oa; logic sar;
    logic [RN-1:0] d, p;
    logic [RN-1:0] exp_peak [SIZE];
    exp_peak = '{16'd7, 16'd88, 16'd21, 16'd263, 16'd35, 16'd42, 16'd55, 16'd55};
    core_mem = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    run_frame(16, 5, -1, ns, fs, ls, nf, fa, no, oa, sar);
    $display("overrun: shifts=%0d frames=%0d at=%0d overruns=%0d at=%0d", ns, nf, fa, no, oa);
    if (no !== 1 || oa !== 5) begin
      errors++; $display("FAIL overrun_pulse: count=%0d at=%0d required 1 5", no, oa);
    end
    checks++;
    if (ns !== 7 || nf !== 1 || fa !== 10) begin
      errors++; $display("FAIL overrun_drain: shifts=%0d frames=%0d at=%0d required 7 1 10", ns, nf, fa);
    end
    checks++;
    for (int k = 0; k < SIZE; k++) begin
      read_bin(AW'(k), d, p);
      if (d !== core_mem[k] || p !== exp_peak[k]) begin
        errors++; $display("FAIL overrun_read bin %0d: data=%0d peak=%0d required %0d %0d", k, d, p, core_mem[k], exp_peak[k]);
      end
      checks++;
    end
  endtask

  task automatic test_mid_reset;
    int ns, fs, ls, nf, fa, no, oa; logic sar;
    logic [RN-1:0] d, p;
    core_mem = '{default: 16'd999};
    run_frame(14, -1, 4, ns, fs, ls, nf, fa, no, oa, sar);
    $display("mid_reset: shift_after=%b frames=%0d", sar, nf);
    if (sar !== 1'b0 || nf !== 0) begin
      errors++; $display("FAIL mid_reset_ctrl: shift_after=%b frames=%0d required 0 0", sar, nf);
    end
    checks++;
    for (int k = 0; k < SIZE; k++) begin
      read_bin(AW'(k), d, p);
      if (d !== 16'd0 || p !== 16'd0) begin
        errors++; $display("FAIL mid_reset_read bin %0d: data=%0d peak=%0d required 0 0", k, d, p);
      end
      checks++;
    end
    core_mem = '{16'd7, 16'd14, 16'd21, 16'd28, 16'd35, 16'd42, 16'd49, 16'd56};
    run_frame(14, -1, -1, ns, fs, ls, nf, fa, no, oa, sar);
    $display("after_reset frame: shifts=%0d frames=%0d at=%0d", ns, nf, fa);
    if (ns !== 7 || nf !== 1 || fa !== 10) begin
      errors++; $display("FAIL after_reset_frame: shifts=%0d frames=%0d at=%0d required 7 1 10", ns, nf, fa);
    end
    checks++;
    for (int k = 0; k < SIZE; k++) begin
      read_bin(AW'(k), d, p);
      if (d !== core_mem[k] || p !== core_mem[k]) begin
        errors++; $display("FAIL after_reset_read bin %0d: data=%0d peak=%0d required %0d %0d", k, d, p, core_mem[k], core_mem[k]);
      end
      checks++;
    end
  endtask

  // Bank 1 holds cur[3] = 28 on entry; frame A fills bank 0 (cur[3] = 44),
  // frame B fills bank 1 (cur[3] = 52).
  task automatic test_back_to_back;
    int nf, no, f1, f2;
    logic [RN-1:0] exp;
    nf = 0; no = 0; f1 = -1; f2 = -1;
    core_mem = '{16'd11, 16'd22, 16'd33, 16'd44, 16'd55, 16'd66, 16'd77, 16'd88};
    @(posedge clk); #1;
    rd_addr = 3'd3;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      done = (c == 0) || (c == 10);
      if (c == 10)
        core_mem = '{16'd13, 16'd26, 16'd39, 16'd52, 16'd65, 16'd78, 16'd91, 16'd104};
      @(negedge clk);
      if (frame === 1'b1) begin
        nf++;
        if (f1 < 0) f1 = c; else f2 = c;
      end
      if (overrun === 1'b1) no++;
      if (c >= 1) begin
        exp = (c <= 10) ? 16'd28 : ((c <= 20) ? 16'd44 : 16'd52);
        if (rd_data !== exp) begin
          errors++; $display("FAIL b2b_read cycle %0d: data=%0d required %0d", c, rd_data, exp);
        end
        checks++;
      end
    end
    @(posedge clk); #1;
    done = 1'b0;
    $display("back_to_back: frames=%0d at %0d and %0d overruns=%0d", nf, f1, f2, no);
    if (nf !== 2 || f1 !== 10 || f2 !== 20 || no !== 0) begin
      errors++; $display("FAIL b2b_frames: frames=%0d at=%0d,%0d overruns=%0d required 2 10,20 0", nf, f1, f2, no);
    end
    checks++;
  endtask

  initial begin
    core_mem = '{default: 16'd0};
    test_reset;
    test_first_frame;
    test_decay;
    test_freeze;
    test_overrun;
    test_mid_reset;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_reader.md
# fft_reader

Consumer for the FFT core's result port. On each `done` pulse it drives `shift` to drain all SIZE magnitude bins from `fft_data` and captures them into a double-buffered spectrum store with per-bin peak-hold and decay. The completed frame is then presented to the display/renderer through a registered random-access read port. It sits between the FFT core and the spectrum display generator, in the same clock domain as both.

## Interface
- `RN`, 16: bin magnitude width, matching the FFT core's result width; unsigned.
- `SIZE`, 64: bins per frame; power of two, ≥ 4.
- `DECAY`, 3: peak decay shift; each frame the held peak loses peak >> DECAY. With DECAY = 0 there is no hold.
- `clk`  in  1: clock.
- `n_reset`  in  1: reset. One clock; reset is synchronous and active-low.
- `done`  in  1: FFT result ready (pulse); bin 0 is in the core's output latch.
- `shift`  out  1: advance the FFT core's output latch by one bin.
- `fft_data`  in  RN: registered magnitude from the FFT core; reflects the latch head one cycle late.
- `en`  in  1: 1 = capture and publish frames; 0 = freeze display (still drains the core).
- `rd_addr`  in  log2(SIZE): display read bin index.
- `rd_data`  out  RN: current magnitude of bin `rd_addr`, one cycle after the address.
- `rd_peak`  out  RN: held peak of bin `rd_addr`, one cycle after the address.
- `frame`  out  1: one-cycle pulse when a new frame becomes visible.
- `overrun`  out  1: one-cycle pulse when `done` arrives while a drain is in progress.

## Operation
- Two banks, each holding SIZE × {cur, peak}. `disp` selects the read bank; writes go to bank `~disp`.
- States:
  - IDLE: `done` = 1 → WAIT.
  - WAIT: one cycle, `shift` = 1 → RUN with idx = 0.
  - RUN: capture bin idx on each cycle; `shift` = 1 while idx ≤ SIZE−3; idx = SIZE−1 → IDLE.
- Capture of bin k, when `en` was 1 at entry to WAIT (latched once per frame):
  - write cur[k] = `fft_data`;
  - write peak[k] = max(`fft_data`, p − (p >> DECAY)), where p = peak[k] of the display bank;
  - all arithmetic is unsigned RN-bit; no overflow is possible because the decayed value ≤ p.
- End of RUN with the latched enable = 1: toggle `disp` and pulse `frame`. With latched enable = 0: nothing is written, there is no swap, and no `frame` pulse.
- `done` seen in WAIT or RUN: the in-progress drain continues unchanged and `overrun` pulses. The new result is not re-read, because the core's shift has priority over its load.
- Read port: `rd_data` and `rd_peak` are registered from bank `disp` at `rd_addr`. A swap is visible to reads issued in or after the `frame` cycle.

## Timing
- Let cycle d be the cycle with `done` = 1 in IDLE.
- `shift` = 1 in cycles d+1 … d+SIZE−1, which is SIZE−1 pulses.
- Bin k is captured from `fft_data` in cycle d+2+k, for k = 0 … SIZE−1.
- `disp` toggles at the end of cycle d+SIZE+1. `frame` = 1 in cycle d+SIZE+2, and the state is IDLE in that cycle.
- A `done` in cycle d+SIZE+2 starts a new frame with no gap.
- Read latency is 1 cycle, with no stall.
- Reset (`n_reset` = 0 at a clock edge):
  - outputs: `shift` = 0, `frame` = 0, `overrun` = 0, `rd_data` = 0, `rd_peak` = 0;
  - state IDLE, idx = 0, `disp` = 0;
  - all cur and peak entries in both banks = 0.
- Reset mid-drain: the frame is abandoned with no swap and no `frame` pulse. The partially shifted core latch is reloaded by its next `done`.
- `done` held high for more than one cycle: only the first cycle starts a frame. Later high cycles during WAIT/RUN each pulse `overrun`.

## Test plan
- SIZE = 8, DECAY = 3. After reset, pulse `done` with a core model supplying bins 10, 20, …, 80.
  - Expect `shift` high for exactly 7 cycles starting at d+1, and `frame` at d+10.
  - Then reading addresses 0…7 gives `rd_data` = 10…80 and `rd_peak` = 10…80.
- Second frame with all bins 0.
  - Expect `rd_data` = 0 and `rd_peak` = p − (p >> 3): for example bin 7 shows 80 → 70, and bin 0 shows 10 → 9.
- Hold `en` = 0 during a frame of all bins 500.
  - Expect `shift` still pulsed 7 times, no `frame` pulse, and read data unchanged.
  - Then `en` = 1 for the next frame: new values appear.
- Pulse `done` again at d+5.
  - Expect `overrun` pulse at d+5, the original frame completing normally with `frame` at d+10, and no second drain.
- Assert `n_reset` = 0 at d+4.
  - Expect `shift` = 0 in the next cycle, no `frame`, all reads return 0.
  - A subsequent `done` drains a full frame correctly.
- Back-to-back: `done` at d and at d+SIZE+2.
  - Expect two `frame` pulses 10 cycles apart and no `overrun`.
  - `rd_addr` sampled continuously switches atomically at the `frame` cycle.
